io_request_controller: RTL and testbench
========================================

# io_request_controller

Sequences memory-mapped I/O accesses from the CPU memory stage onto the keypad/switch input path and the display output register. It raises `input_enable` toward the input unit and waits for the user to confirm with Enter, then returns the keypad or switch value. It holds each display write on screen for a programmable number of cycles. The pipeline is stalled for the whole access; the stall is frozen while the CPU is paused.

## Interface
- `ISA_WIDTH`, 32, data/address width
- `IN_ADDR`, 32'hFFFF_FC70, load address serviced as user input
- `OUT_ADDR`, 32'hFFFF_FC60, store address serviced as display output
- `OUT_HOLD_CYCLES`, 16, cycles a display write holds the pipeline (legal range 1..65535)

Ports:
- `clk`  in  1  system clock, all state on posedge
- `rst_n`  in  1  reset, asynchronous, active-low
- `mem_read`  in  1  memory-stage load
- `mem_write`  in  1  memory-stage store
- `mem_addr`  in  ISA_WIDTH  memory-stage address
- `mem_wdata`  in  ISA_WIDTH  store data
- `input_complete`  in  1  input unit: user pressed Enter (sticky until next request)
- `keypad_data`  in  ISA_WIDTH  input unit keypad value
- `switch_enable`  in  1  input unit: switches selected
- `switch_data`  in  16  board switches
- `cpu_pause`  in  1  input unit: CPU paused
- `input_enable`  out  1  request to input unit
- `io_stall`  out  1  hold pipeline
- `io_rdata`  out  ISA_WIDTH  load result
- `io_rdata_valid`  out  1  one-cycle strobe with `io_rdata`
- `display_value`  out  ISA_WIDTH  last value written to OUT_ADDR
- `display_valid`  out  1  high from first display write until reset

## Operation
- States: IDLE, IN_REQ, IN_WAIT, OUT_HOLD, RELEASE.
- Request decode (IDLE only):
  - `rd_hit = mem_read & mem_addr==IN_ADDR`
  - `wr_hit = mem_write & mem_addr==OUT_ADDR`
  - If both `mem_read` and `mem_write` are high, read wins and the write is dropped.
  - Accesses to any other address are ignored.
- IDLE:
  - `rd_hit & ~cpu_pause` → IN_REQ.
  - `wr_hit & ~cpu_pause` → OUT_HOLD; latch `display_value <= mem_wdata`; set `display_valid`; load `hold_cnt <= OUT_HOLD_CYCLES-1`.
  - When `cpu_pause` is high, no request is accepted.
- IN_REQ: `input_enable=1` for exactly one cycle; → IN_WAIT.
- IN_WAIT:
  - Ignore `input_complete` on the first IN_WAIT cycle, which is the stale sticky value.
  - Afterwards, on `input_complete=1` latch `io_rdata` as `{16'b0, switch_data}` if `switch_enable` is high at that edge, else `keypad_data`; → RELEASE.
- OUT_HOLD:
  - Decrement `hold_cnt` each cycle `cpu_pause=0`; freeze it while paused.
  - At `hold_cnt==0` with no pause → RELEASE.
- RELEASE: one cycle; → IDLE unconditionally. `io_rdata_valid=1` only if entered from IN_WAIT.
- `io_stall` (combinational) = `(state != IDLE && state != RELEASE) | (state == IDLE & (rd_hit | wr_hit))`. It is low in RELEASE so the pipeline advances; requests presented during RELEASE are not decoded.
- `cpu_pause` freezes all state except IN_WAIT, which still accepts `input_complete`.
- `hold_cnt` is 16 bits with no wrap: decrement only when nonzero.

## Timing
- Reset values:
  - state IDLE; `input_enable` 0; `io_stall` 0 when no hit is decoded; `io_rdata` 0; `io_rdata_valid` 0; `display_value` 0; `display_valid` 0; `hold_cnt` 0.
  - Reset mid-access aborts the access with no result strobe.
- Load, hit decoded in cycle T:
  - `io_stall` high in T.
  - `input_enable` high in T+1.
  - `input_complete` is sampled from T+3 onward.
  - If sampled high at edge E, RELEASE is the next cycle with `io_rdata_valid`; minimum is RELEASE at T+4.
- Store, hit decoded in cycle T:
  - `display_value` updates at the end of T.
  - Stall lasts T..T+OUT_HOLD_CYCLES.
  - RELEASE at T+OUT_HOLD_CYCLES+1, plus one cycle for each paused cycle.
- `io_rdata` holds its value until the next completed load.

## Test plan
- Reset mid-IN_WAIT → all outputs return to reset values; no `io_rdata_valid` strobe.
- Load IN_ADDR; `input_complete` held 1 (stale) in first IN_WAIT cycle then dropped; asserted again at T+10 with `keypad_data`=1234 → exactly one `input_enable` pulse; stale value ignored; `io_rdata`=1234 with `io_rdata_valid` in the following RELEASE cycle; stall low only in RELEASE.
- Same load with `switch_enable`=1 and `switch_data`=16'hA5A5 → `io_rdata`=32'h0000_A5A5.
- Store 0xDEAD_BEEF to OUT_ADDR, OUT_HOLD_CYCLES=4, no pause → `display_value`=0xDEADBEEF; `display_valid`=1; stall high for 5 cycles; RELEASE on the 6th.
- Same store with `cpu_pause` high for 3 cycles mid-hold → RELEASE delayed exactly 3 cycles; a new IO hit during pause in IDLE keeps stall high and is not accepted until the pause clears.
- `mem_read` and `mem_write` together at IN_ADDR/OUT_ADDR → load serviced; `display_value` unchanged. Store to a non-IO address → no stall, no state change.

Source files
------------

// File: rtl/io_request_controller.sv
// Sequences memory-mapped I/O: keypad/switch loads via input_enable/input_complete handshake,
// and display stores held on screen for OUT_HOLD_CYCLES; stalls the pipeline for the whole access.
module io_request_controller #(
  parameter int unsigned             ISA_WIDTH       = 32,
  parameter logic [ISA_WIDTH-1:0]    IN_ADDR         = 32'hFFFF_FC70,
  parameter logic [ISA_WIDTH-1:0]    OUT_ADDR        = 32'hFFFF_FC60,
  parameter int unsigned             OUT_HOLD_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [ISA_WIDTH-1:0] mem_addr,
  input  logic [ISA_WIDTH-1:0] mem_wdata,
  input  logic                 input_complete,
  input  logic [ISA_WIDTH-1:0] keypad_data,
  input  logic                 switch_enable,
  input  logic [15:0]          switch_data,
  input  logic                 cpu_pause,
  output logic                 input_enable,
  output logic                 io_stall,
  output logic [ISA_WIDTH-1:0] io_rdata,
  output logic                 io_rdata_valid,
  output logic [ISA_WIDTH-1:0] display_value,
  output logic                 display_valid
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    IN_REQ   = 3'd1,
    IN_WAIT  = 3'd2,
    OUT_HOLD = 3'd3,
    RELEASE  = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [15:0]            hold_cnt_q, hold_cnt_d;
  logic                   first_wait_q, first_wait_d;
  logic [ISA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                   rvalid_q, rvalid_d;
  logic [ISA_WIDTH-1:0]   disp_q, disp_d;
  logic                   dvalid_q, dvalid_d;
  logic                   rd_hit, wr_hit;

  // A simultaneous read suppresses the write so a load is never lost.
  assign rd_hit = mem_read & (mem_addr == IN_ADDR);
  assign wr_hit = mem_write & ~mem_read & (mem_addr == OUT_ADDR);

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    first_wait_d = first_wait_q;
    rdata_d      = rdata_q;
    rvalid_d     = 1'b0;
    disp_d       = disp_q;
    dvalid_d     = dvalid_q;
    input_enable = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!cpu_pause) begin
          if (rd_hit) begin
            state_d = IN_REQ;
          end else if (wr_hit) begin
            state_d    = OUT_HOLD;
            disp_d     = mem_wdata;
            dvalid_d   = 1'b1;
            hold_cnt_d = 16'(OUT_HOLD_CYCLES - 1);
          end
        end
      end
      IN_REQ: begin
        // Pulse is withheld while paused so the input unit sees exactly one request.
        if (!cpu_pause) begin
          input_enable = 1'b1;
          state_d      = IN_WAIT;
          first_wait_d = 1'b1;
        end
      end
      IN_WAIT: begin
        // The first cycle still shows the previous request's sticky Enter.
        first_wait_d = 1'b0;
        if (!first_wait_q && input_complete) begin
          rdata_d  = switch_enable ? {{(ISA_WIDTH-16){1'b0}}, switch_data} : keypad_data;
          rvalid_d = 1'b1;
          state_d  = RELEASE;
        end
      end
      OUT_HOLD: begin
        if (!cpu_pause) begin
          if (hold_cnt_q == 16'd0) begin
            state_d = RELEASE;
          end else begin
            hold_cnt_d = hold_cnt_q - 16'd1;
          end
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hold_cnt_q   <= 16'd0;
      first_wait_q <= 1'b0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
      disp_q       <= '0;
      dvalid_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      first_wait_q <= first_wait_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
      disp_q       <= disp_d;
      dvalid_q     <= dvalid_d;
    end
  end

  assign io_stall       = ((state_q != IDLE) && (state_q != RELEASE)) |
                          ((state_q == IDLE) & (rd_hit | wr_hit));
  assign io_rdata       = rdata_q;
  assign io_rdata_valid = rvalid_q;
  assign display_value  = disp_q;
  assign display_valid  = dvalid_q;

endmodule

// File: tb/tb_io_request_controller.sv
// Directed bench for io_request_controller: loads, stores, pause, reset abort, decode corners.
module tb_io_request_controller;

  localparam logic [31:0] IN_A  = 32'hFFFF_FC70;
  localparam logic [31:0] OUT_A = 32'hFFFF_FC60;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata;
  logic        input_complete;
  logic [31:0] keypad_data;
  logic        switch_enable;
  logic [15:0] switch_data;
  logic        cpu_pause;
  logic        input_enable, io_stall, io_rdata_valid, display_valid;
  logic [31:0] io_rdata, display_value;

  int errors = 0;
  int checks = 0;

  io_request_controller #(
    .ISA_WIDTH(32), .IN_ADDR(IN_A), .OUT_ADDR(OUT_A), .OUT_HOLD_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .input_complete(input_complete), .keypad_data(keypad_data),
    .switch_enable(switch_enable), .switch_data(switch_data), .cpu_pause(cpu_pause),
    .input_enable(input_enable), .io_stall(io_stall),
    .io_rdata(io_rdata), .io_rdata_valid(io_rdata_valid),
    .display_value(display_value), .display_valid(display_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven for the new cycle.
  task automatic go();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;
    input_complete = 1'b0; keypad_data = '0; switch_enable = 1'b0; switch_data = '0;
    cpu_pause = 1'b0;
    go(); go(); #1;
    chk("rst_stall", {31'b0, io_stall}, 32'd0);
    chk("rst_ien", {31'b0, input_enable}, 32'd0);
    chk("rst_rdata", io_rdata, 32'd0);
    chk("rst_rvalid", {31'b0, io_rdata_valid}, 32'd0);
    chk("rst_disp", display_value, 32'd0);
    chk("rst_dvalid", {31'b0, display_valid}, 32'd0);
    go(); rst_n = 1'b1;

    // Reset mid-IN_WAIT aborts with no strobe
    go(); mem_read = 1'b1; mem_addr = IN_A; #1;
    chk("ab_stall_T", {31'b0, io_stall}, 32'd1);
    go(); mem_read = 1'b0; #1;
    chk("ab_ien_T1", {31'b0, input_enable}, 32'd1);
    go(); input_complete = 1'b1; #1;
    chk("ab_stall_wait", {31'b0, io_stall}, 32'd1);
    rst_n = 1'b0; #1;
    chk("ab_stall_rst", {31'b0, io_stall}, 32'd0);
    chk("ab_ien_rst", {31'b0, input_enable}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      go(); #1;
      chk("ab_rvalid", {31'b0, io_rdata_valid}, 32'd0);
      chk("ab_rdata", io_rdata, 32'd0);
    end
    go(); input_complete = 1'b0; rst_n = 1'b1;
    go(); #1;
    chk("ab_idle_stall", {31'b0, io_stall}, 32'd0);

    // Keypad load with stale sticky Enter, real Enter at T+10
    go(); mem_read = 1'b1; mem_addr = IN_A; input_complete = 1'b1; keypad_data = 32'd1234; #1;
    chk("kp_stall_T", {31'b0, io_stall}, 32'd1);
    chk("kp_ien_T", {31'b0, input_enable}, 32'd0);
    go(); mem_read = 1'b0; #1;
    chk("kp_ien_T1", {31'b0, input_enable}, 32'd1);
    chk("kp_stall_T1", {31'b0, io_stall}, 32'd1);
    go(); #1;
    chk("kp_stale_ien", {31'b0, input_enable}, 32'd0);
    chk("kp_stale_stall", {31'b0, io_stall}, 32'd1);
    for (int c = 3; c <= 9; c++) begin
      go(); input_complete = 1'b0; #1;
      chk("kp_wait_stall", {31'b0, io_stall}, 32'd1);
      chk("kp_wait_ien", {31'b0, input_enable}, 32'd0);
      chk("kp_wait_rvalid", {31'b0, io_rdata_valid}, 32'd0);
    end
    go(); input_complete = 1'b1; #1;
    chk("kp_T10_stall", {31'b0, io_stall}, 32'd1);
    go(); input_complete = 1'b0; keypad_data = 32'd9; #1;
    chk("kp_rel_stall", {31'b0, io_stall}, 32'd0);
    chk("kp_rel_rvalid", {31'b0, io_rdata_valid}, 32'd1);
    chk("kp_rel_rdata", io_rdata, 32'd1234);
    go(); #1;
    chk("kp_post_rvalid", {31'b0, io_rdata_valid}, 32'd0);
    chk("kp_post_rdata", io_rdata, 32'd1234);
    chk("kp_post_stall", {31'b0, io_stall}, 32'd0);

    // Switch load at minimum latency: RELEASE at T+4
    go(); mem_read = 1'b1; mem_addr = IN_A; switch_enable = 1'b1; switch_data = 16'hA5A5;
    keypad_data = 32'd999; input_complete = 1'b1; #1;
    chk("sw_stall_T", {31'b0, io_stall}, 32'd1);
    go(); mem_read = 1'b0; #1;
    chk("sw_ien_T1", {31'b0, input_enable}, 32'd1);
    go(); #1;
    chk("sw_stall_T2", {31'b0, io_stall}, 32'd1);
    go(); #1;
    chk("sw_stall_T3", {31'b0, io_stall}, 32'd1);
    chk("sw_rvalid_T3", {31'b0, io_rdata_valid}, 32'd0);
    go(); input_complete = 1'b0; switch_enable = 1'b0; #1;
    chk("sw_rel_rvalid", {31'b0, io_rdata_valid}, 32'd1);
    chk("sw_rel_rdata", io_rdata, 32'h0000_A5A5);
    chk("sw_rel_stall", {31'b0, io_stall}, 32'd0);

    // Store, hold 4, no pause: stall T..T+4, RELEASE T+5
    go(); mem_write = 1'b1; mem_addr = OUT_A; mem_wdata = 32'hDEAD_BEEF; #1;
    chk("st_stall_T", {31'b0, io_stall}, 32'd1);
    chk("st_dvalid_T", {31'b0, display_valid}, 32'd0);
    for (int c = 1; c <= 4; c++) begin
      go(); mem_write = 1'b0; #1;
      chk("st_stall_hold", {31'b0, io_stall}, 32'd1);
      chk("st_disp", display_value, 32'hDEAD_BEEF);
      chk("st_dvalid", {31'b0, display_valid}, 32'd1);
    end
    go(); #1;
    chk("st_rel_stall", {31'b0, io_stall}, 32'd0);
    chk("st_rel_rvalid", {31'b0, io_rdata_valid}, 32'd0);
    chk("st_rdata_kept", io_rdata, 32'h0000_A5A5);

    // Store with 3 paused cycles (T+3..T+5): RELEASE at T+8
    go(); mem_write = 1'b1; mem_addr = OUT_A; mem_wdata = 32'h1234_5678; #1;
    chk("sp_stall_T", {31'b0, io_stall}, 32'd1);
    for (int c = 1; c <= 7; c++) begin
      go(); mem_write = 1'b0; cpu_pause = (c >= 3 && c <= 5); #1;
      chk("sp_stall_hold", {31'b0, io_stall}, 32'd1);
    end
    go(); cpu_pause = 1'b0; #1;
    chk("sp_rel_stall", {31'b0, io_stall}, 32'd0);
    chk("sp_disp", display_value, 32'h1234_5678);

    // IO hit in IDLE while paused: stalls but is not accepted until pause clears
    for (int c = 0; c < 2; c++) begin
      go(); cpu_pause = 1'b1; mem_read = 1'b1; mem_addr = IN_A; #1;
      chk("ph_stall", {31'b0, io_stall}, 32'd1);
      chk("ph_ien", {31'b0, input_enable}, 32'd0);
    end
    go(); #1;
    chk("ph_still_idle_ien", {31'b0, input_enable}, 32'd0);
    cpu_pause = 1'b0; #1;
    chk("ph_unpause_stall", {31'b0, io_stall}, 32'd1);
    go(); mem_read = 1'b0; #1;
    chk("ph_ien", {31'b0, input_enable}, 32'd1);
    go(); #1;
    go(); input_complete = 1'b1; keypad_data = 32'd77; #1;
    chk("ph_wait_stall", {31'b0, io_stall}, 32'd1);
    go(); input_complete = 1'b0; #1;
    chk("ph_rel_rvalid", {31'b0, io_rdata_valid}, 32'd1);
    chk("ph_rel_rdata", io_rdata, 32'd77);

    // Read and write together at IN_ADDR: load wins, display untouched
    go(); mem_read = 1'b1; mem_write = 1'b1; mem_addr = IN_A; mem_wdata = 32'h0000_0BAD; #1;
    chk("rw_stall_T", {31'b0, io_stall}, 32'd1);
    go(); mem_read = 1'b0; mem_write = 1'b0; #1;
    chk("rw_ien", {31'b0, input_enable}, 32'd1);
    chk("rw_disp_T1", display_value, 32'h1234_5678);
    go(); #1;
    go(); input_complete = 1'b1; keypad_data = 32'd55; #1;
    go(); input_complete = 1'b0; #1;
    chk("rw_rel_rdata", io_rdata, 32'd55);
    chk("rw_rel_rvalid", {31'b0, io_rdata_valid}, 32'd1);
    chk("rw_disp", display_value, 32'h1234_5678);

    // Store to a non-IO address: ignored
    go(); mem_write = 1'b1; mem_addr = 32'h0000_1000; mem_wdata = 32'hCAFE_F00D; #1;
    chk("nio_stall", {31'b0, io_stall}, 32'd0);
    go(); mem_write = 1'b0; #1;
    chk("nio_stall_next", {31'b0, io_stall}, 32'd0);
    chk("nio_ien", {31'b0, input_enable}, 32'd0);
    chk("nio_disp", display_value, 32'h1234_5678);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
